bin2bcd_seq: RTL
================

// Module: bin2bcd_seq
// PURPOSE
// - Sequential binary-to-BCD converter using shift-add-3 (double dabble) for the
//   wave generator's frequency/amplitude display path.
// - Converts one input bit per clock, so a wide setting costs one adder per digit
//   rather than a combinational cascade.
// - Handshake: start / busy / done. Sits between the setting registers and the
//   7-segment scan driver.
// PARAMETERS
// - WIDTH   12  binary input width in bits, >= 1
// - DIGITS  4   number of BCD output digits, >= 1; digit 0 is the least significant
// PORTS
// - clk      in   1         system clock, rising edge
// - rst_n    in   1         asynchronous, active-low reset
// - start    in   1         request a conversion; honoured only in IDLE
// - bin_in   in   WIDTH     binary value; sampled on the clk edge that accepts start
// - busy     out  1         high while state != IDLE
// - done     out  1         one-cycle pulse: bcd_out/ovf updated on this cycle
// - bcd_out  out  4*DIGITS  packed BCD; digit k = bcd_out[4k+3:4k]
// - ovf      out  1         value did not fit in DIGITS digits (>= 10^DIGITS)
// - blank    out  DIGITS    leading-zero mask; present only with BCD_BLANK_EN
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE; busy=0, done=0, bcd_out=0, ovf=0, blank=0;
//   internal shift/digit/count registers cleared.
// - FSM states: IDLE -> SHIFT -> DONE -> IDLE.
// - IDLE, start=1: load shift reg <= bin_in, digits <= 0, cnt <= WIDTH, ovf_acc <= 0;
//   go to SHIFT. start=0: stay in IDLE.
// - SHIFT, every cycle:
//   - first, each digit >= 5 gets +3 (4-bit add, all digits in parallel);
//   - then shift left by one: {digits, shreg} <<= 1;
//   - the bit leaving the top digit is ORed into ovf_acc; cnt decrements;
//   - exit to DONE after the shift that takes cnt from 1 to 0.
// - DONE (one cycle): bcd_out <= digits, ovf <= ovf_acc, done=1; go to IDLE.
// - Latency: the start edge is cycle 0; done is high in cycle WIDTH+1; busy is high
//   in cycles 1..WIDTH+1. Next start is accepted in cycle WIDTH+2 at the earliest.
// - start while busy is ignored. bin_in changes after acceptance do not affect the
//   result.
// - bcd_out/ovf hold their last values until the next DONE. They are never
//   partially updated.
// - On ovf=1, bcd_out holds the low DIGITS digits of the true value
//   (value mod 10^DIGITS).
// - Reset mid-conversion aborts immediately: outputs return to their reset values
//   and no done pulse follows.
// - Every digit register stays in 0..9 at every cycle boundary.
// CONFIGURATION
// - BCD_BLANK_EN defined:
//   - the blank port exists, registered and updated with bcd_out in DONE;
//   - blank[k]=1 iff digit k and all higher digits are 0 (k >= 1);
//   - blank[0] is always 0, so "0" is displayed as one digit;
//   - blank = 0 whenever ovf = 1.
// - BCD_BLANK_EN undefined: no blank port and no blanking logic. All other
//   behaviour is identical.
// TESTING
// - WIDTH=12, DIGITS=4: bin_in=4095 with start -> done in cycle 13,
//   bcd_out=16'h4095, ovf=0.
// - bin_in=0 -> bcd_out=16'h0000, ovf=0; blank=4'b1110 with BCD_BLANK_EN.
//   bin_in=37 -> 16'h0037, blank=4'b1100.
// - WIDTH=12, DIGITS=3: bin_in=999 -> 12'h999, ovf=0. bin_in=1000 -> 12'h000, ovf=1.
//   bin_in=4095 -> 12'h095, ovf=1.
// - Pulse start=1 with bin_in=123 in cycle 5 while busy: ignored. The running
//   conversion result is unchanged and exactly one done pulse occurs.
// - Assert rst_n=0 in cycle 6 of a 4095 conversion -> busy=0 and bcd_out=0 at once.
//   No done pulse. A following conversion of 2048 -> 16'h2048.
// - Back-to-back: start in cycle WIDTH+2 after each done, 200 random bin_in ->
//   every bcd_out matches the golden decimal conversion.

Source files
------------

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per clock.
// Optional leading-zero blanking mask is enabled by defining BCD_BLANK_EN.

module bcd_digit_cell (
    input  logic [3:0] d,
    input  logic       cin,
    output logic [3:0] nxt,
    output logic       cout
);
    logic [3:0] adj;

    // Digits stay in 0..9, so the +3 correction never exceeds 12.
    always_comb begin
        adj  = (d >= 4'd5) ? d + 4'd3 : d;
        nxt  = {adj[2:0], cin};
        cout = adj[3];
    end
endmodule

module bin2bcd_seq #(
    parameter int WIDTH  = 12,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  ovf
`ifdef BCD_BLANK_EN
    ,
    output logic [DIGITS-1:0]     blank
`endif
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t                  state;
    logic [WIDTH-1:0]        shreg;
    logic [DIGITS-1:0][3:0]  digits;
    logic [DIGITS-1:0][3:0]  digits_nxt;
    logic [DIGITS:0]         carry;
    logic [CW-1:0]           cnt;
    logic                    ovf_acc;
    logic                    ovf_nxt;

    assign carry[0] = shreg[WIDTH-1];
    assign ovf_nxt  = ovf_acc | carry[DIGITS];

    generate
        for (genvar k = 0; k < DIGITS; k++) begin : g_dig
            bcd_digit_cell u_cell (
                .d    (digits[k]),
                .cin  (carry[k]),
                .nxt  (digits_nxt[k]),
                .cout (carry[k+1])
            );
        end
    endgenerate

`ifdef BCD_BLANK_EN
    logic [DIGITS-1:0] blank_nxt;
    logic              zero_above;

    // Walk down from the top digit; digit 0 is never blanked.
    always_comb begin
        blank_nxt  = '0;
        zero_above = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zero_above   = zero_above & (digits_nxt[k] == 4'd0);
            blank_nxt[k] = zero_above & ~ovf_nxt;
        end
    end
`endif

    // Results are captured on the final shift so done and bcd_out appear together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            bcd_out <= '0;
            ovf     <= 1'b0;
            shreg   <= '0;
            digits  <= '0;
            cnt     <= '0;
            ovf_acc <= 1'b0;
`ifdef BCD_BLANK_EN
            blank   <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        shreg   <= bin_in;
                        digits  <= '0;
                        cnt     <= CW'(WIDTH);
                        ovf_acc <= 1'b0;
                        busy    <= 1'b1;
                        state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    shreg   <= shreg << 1;
                    digits  <= digits_nxt;
                    ovf_acc <= ovf_nxt;
                    cnt     <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        bcd_out <= digits_nxt;
                        ovf     <= ovf_nxt;
                        done    <= 1'b1;
`ifdef BCD_BLANK_EN
                        blank   <= blank_nxt;
`endif
                        state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
